pulse_burst_ctrl: RTL

Sequencer for the mod-N pulse datapath: on a `start` handshake it latches a period and a burst length, runs an internal mod-P phase counter, and emits exactly N one-cycle pulses spaced P cycles apart. It then reports completion with a one-cycle `done` strobe and returns to idle. It sits between control logic (CPU regs or a higher FSM) and any consumer of periodic ticks, replacing hard-wired mod-3 pulse generators where period and count must be programmable.

---
 rtl/pulse_burst_ctrl_if.sv | 28 ++
 rtl/pulse_burst_ctrl.sv | 86 ++++++++
 2 files changed

// File: rtl/pulse_burst_ctrl_if.sv
// Control/status bundle between a burst requester and pulse_burst_ctrl.
// The abort request wire exists only when PULSE_BURST_ABORT_EN is defined.
interface pulse_burst_ctrl_if #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
);
    logic               start;
    logic [CNT_W-1:0]   period;
    logic [BURST_W-1:0] burst_len;
    logic               busy;
    logic               done;
    logic               pulse;
    logic [CNT_W-1:0]   q;
    logic [BURST_W-1:0] pulses_left;
`ifdef PULSE_BURST_ABORT_EN
    logic               abort;

    modport master (output start, period, burst_len, abort,
                    input  busy, done, pulse, q, pulses_left);
    modport slave  (input  start, period, burst_len, abort,
                    output busy, done, pulse, q, pulses_left);
`else
    modport master (output start, period, burst_len,
                    input  busy, done, pulse, q, pulses_left);
    modport slave  (input  start, period, burst_len,
                    output busy, done, pulse, q, pulses_left);
`endif
endinterface

// File: rtl/pulse_burst_ctrl.sv
// Programmable burst sequencer: N one-cycle pulses spaced P cycles apart, then a done strobe.
// Optional feature macro: PULSE_BURST_ABORT_EN (adds an abort request that cancels a running burst).
module pulse_burst_ctrl #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    pulse_burst_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   p_last_q, p_last_d;   // latched P_eff-1
    logic [BURST_W-1:0] left_q, left_d;
    logic               abort_req;
    logic               wrap;

`ifdef PULSE_BURST_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign wrap = (state_q == RUN) && (q_q == p_last_q);

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.pulse       = wrap && !abort_req;
    assign bus.q           = q_q;
    assign bus.pulses_left = left_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            p_last_q <= CNT_W'(1);
            left_q   <= '0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            p_last_q <= p_last_d;
            left_q   <= left_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        p_last_d = p_last_q;
        left_d   = left_q;
        case (state_q)
            IDLE: begin
                // abort outranks start so a requester can flush a stale start
                if (bus.start && !abort_req) begin
                    if (bus.burst_len != '0) begin
                        state_d  = RUN;
                        q_d      = '0;
                        left_d   = bus.burst_len;
                        p_last_d = (bus.period < CNT_W'(2)) ? CNT_W'(1)
                                                            : bus.period - CNT_W'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                    q_d     = '0;
                    left_d  = '0;
                end else if (wrap) begin
                    q_d    = '0;
                    left_d = left_q - BURST_W'(1);
                    if (left_q == BURST_W'(1))
                        state_d = DONE;
                end else begin
                    q_d = q_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
